eq_mix_sequencer: RTL and testbench
===================================

# eq_mix_sequencer

Sample-rate sequencer and band mixer for the three-band equalizer filter bank. Accepts one audio sample per strobe and launches all band filters together. Collects each band's done pulse and captured output, then applies a per-band gain using one shared multiplier. The gains are in the filter bank's Q.16 coefficient format (65536 = 1.0). The summed result is driven to the output stage as a single validated 29-bit sample.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1024: maximum cycles spent in WAIT before forcing completion.
- `W`, default 29: sample and gain width (signed, two's complement).

Ports:
- `clk_i`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `sample_valid_i`  in  1  one-cycle strobe: new input sample.
- `sample_i`  in  W  input sample.
- `gain1_i`, `gain2_i`, `gain3_i`  in  W each  band gains, signed Q.16.
- `clr_flags_i`  in  1  clears the sticky flags.
- `filt_start_o`  out  1  one-cycle start pulse to all band filters (filter `dataf_i`).
- `filt_dato_o`  out  W  sample to the filters; held stable between launches.
- `band_done_i`  in  3  per-band done pulses (filter `dataf_o`), bit k = band k+1.
- `band1_i`, `band2_i`, `band3_i`  in  W each  band filter outputs.
- `mix_o`  out  W  gained sum.
- `mix_valid_o`  out  1  one-cycle strobe: `mix_o` is new.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `overrun_o`  out  1  sticky: a sample was dropped.
- `timeout_o`  out  1  sticky: WAIT expired.

## Operation
FSM states: IDLE, LAUNCH, WAIT, MAC, OUT.

- **IDLE**
  - On `sample_valid_i`: capture `sample_i` into `filt_dato_o`; snapshot gain1..3 into internal registers; go to LAUNCH.
- **LAUNCH**
  - `filt_start_o` = 1 for this cycle only.
  - Clear the done mask, the band capture registers, the timeout counter and the accumulator.
  - Go to WAIT.
- **WAIT**
  - For each k, when `band_done_i[k]` = 1, set `mask[k]` and capture the matching band input into `cap[k]`.
  - A repeat pulse on a bit already set in the mask is ignored (first capture wins).
  - The counter increments every WAIT cycle.
  - Leave for MAC, index 0, when the mask is 3'b111 after this edge's update.
  - If the counter reaches `TIMEOUT_CYC`−1 first: set `timeout_o` and go to MAC. Bands not yet done contribute `cap` = 0.
- **MAC** (3 cycles, index 0..2)
  - Each cycle: `acc <= acc + ((cap[idx] * g[idx]) >>> 16)`.
  - Product is 2W bits signed; arithmetic shift right (floor); `acc` is W+2 bits.
  - After index 2, go to OUT.
- **OUT**
  - `mix_o` <= `acc` reduced to W bits (see Configuration); `mix_valid_o` = 1 for one cycle; go to IDLE.
- **Overrun**
  - `sample_valid_i` in any state other than IDLE drops the sample and sets `overrun_o`.
  - A dropped sample does not alter `filt_dato_o`, the gains or the computation in progress.
- **Sticky flags**
  - `clr_flags_i` clears `overrun_o` and `timeout_o`.
  - If a set and a clear occur in the same cycle, set wins.
- **Gain stability**
  - Gain input changes after the IDLE capture edge have no effect on the current sample.

## Timing
- Reset values: state IDLE, all outputs 0, `mix_o` 0, `filt_dato_o` 0. All internal registers are 0.
- Reset asserted mid-operation aborts immediately; no `mix_valid_o` is produced for that sample.
- `sample_valid_i` sampled at edge E0 produces `filt_start_o` high in the cycle after E0.
- The WAIT exit edge is Ew. The MAC accumulate edges are Ew+1, Ew+2 and Ew+3. `mix_valid_o` is high during the cycle after Ew+4.
- Minimum sample period is 7 cycles plus the filter latency: IDLE(1) + LAUNCH(1) + WAIT(≥1) + MAC(3) + OUT(1).
- `sample_valid_i` in the same cycle that OUT returns to IDLE counts as an overrun. A sample is accepted only when the state register is IDLE.
- Done pulses arriving in LAUNCH, MAC, OUT or IDLE are ignored.

## Configuration
- `EQ_MIX_SAT_EN` defined:
  - OUT clamps `acc` to the range [−2^(W−1), 2^(W−1)−1].
- `EQ_MIX_SAT_EN` undefined:
  - OUT takes `acc[W−1:0]`, i.e. wraps modulo 2^W.
- The MAC arithmetic is identical in both builds.

## Test plan
- **Unity mix:** gains 65536, 65536, 65536; bands 100, 200, 300; all three done bits pulsed together.
  - Required: `mix_o` = 600.
  - Required: `mix_valid_o` exactly 4 cycles after the done edge.
  - Required: `filt_start_o` exactly one pulse.
- **Rounding/sign:** gain1 = 32768, others 0.
  - band1 = 1001 → `mix_o` = 500.
  - band1 = −1001 → `mix_o` = −501.
- **Saturation:** unity gains; bands 200000000 each.
  - With `EQ_MIX_SAT_EN`: `mix_o` = 268435455.
  - Without it: `mix_o` = 63129088.
- **Timeout:** `TIMEOUT_CYC` = 16; bands 1 and 2 done with values 10 and 20; band 3 never done.
  - Required: `timeout_o` set; `mix_o` = 30.
  - `clr_flags_i` then clears `timeout_o`.
- **Overrun / gain snapshot:** second `sample_valid_i` during WAIT, with gains changed at the same time.
  - Required: `overrun_o` = 1; `filt_dato_o` unchanged; result computed with the original gains.
  - Required: no second `filt_start_o`.
- **Async reset mid-MAC:** `reset` low for 1 cycle during MAC.
  - Required: all outputs 0 immediately; no `mix_valid_o`.
  - Required: the next sample after reset is processed normally.

Source files
------------

// File: rtl/eq_mix_sequencer.sv
// Three-band EQ sequencer: launches the band filters, collects their outputs and mixes them
// with Q.16 gains on one shared multiplier. Define EQ_MIX_SAT_EN to saturate instead of wrap.
module eq_mix_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned W           = 29
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic         sample_valid_i,
  input  logic [W-1:0] sample_i,
  input  logic [W-1:0] gain1_i,
  input  logic [W-1:0] gain2_i,
  input  logic [W-1:0] gain3_i,
  input  logic         clr_flags_i,
  output logic         filt_start_o,
  output logic [W-1:0] filt_dato_o,
  input  logic [2:0]   band_done_i,
  input  logic [W-1:0] band1_i,
  input  logic [W-1:0] band2_i,
  input  logic [W-1:0] band3_i,
  output logic [W-1:0] mix_o,
  output logic         mix_valid_o,
  output logic         busy_o,
  output logic         overrun_o,
  output logic         timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StMac, StOut} state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          dato_q, dato_d;
  logic signed [W-1:0]   gain_q [3];
  logic signed [W-1:0]   gain_d [3];
  logic signed [W-1:0]   cap_q [3];
  logic signed [W-1:0]   cap_d [3];
  logic [2:0]            mask_q, mask_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic signed [W+1:0]   acc_q, acc_d;
  logic [W-1:0]          mix_q, mix_d;
  logic                  mix_valid_q, mix_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

  logic signed [W-1:0]   band_in [3];
  logic signed [W-1:0]   cap_sel, gain_sel;
  logic signed [2*W-1:0] prod;
  logic signed [W+1:0]   term;
  logic [W-1:0]          out_val;
  logic                  unused_prod;

  assign band_in[0] = band1_i;
  assign band_in[1] = band2_i;
  assign band_in[2] = band3_i;

  always_comb begin
    cap_sel  = '0;
    gain_sel = '0;
    case (idx_q)
      2'd0: begin cap_sel = cap_q[0]; gain_sel = gain_q[0]; end
      2'd1: begin cap_sel = cap_q[1]; gain_sel = gain_q[1]; end
      2'd2: begin cap_sel = cap_q[2]; gain_sel = gain_q[2]; end
      default: ;
    endcase
  end

  // Bits [W+17:16] of the full product equal the floored >>>16 result truncated to acc width.
  assign prod        = cap_sel * gain_sel;
  assign term        = prod[W+17:16];
  assign unused_prod = ^{prod[2*W-1:W+18], prod[15:0]};

  always_comb begin
    out_val = acc_q[W-1:0];
`ifdef EQ_MIX_SAT_EN
    if (acc_q[W+1:W-1] != 3'b000 && acc_q[W+1:W-1] != 3'b111) begin
      out_val = acc_q[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    dato_d      = dato_q;
    gain_d      = gain_q;
    cap_d       = cap_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;

    // Clear first so a same-cycle set below takes priority.
    if (clr_flags_i) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (sample_valid_i && state_q != StIdle) overrun_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (sample_valid_i) begin
          dato_d    = sample_i;
          gain_d[0] = gain1_i;
          gain_d[1] = gain2_i;
          gain_d[2] = gain3_i;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        mask_d  = '0;
        cap_d   = '{default: '0};
        cnt_d   = '0;
        idx_d   = '0;
        acc_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        for (int k = 0; k < 3; k++) begin
          if (band_done_i[k] && !mask_q[k]) begin
            mask_d[k] = 1'b1;
            cap_d[k]  = band_in[k];
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (mask_d == 3'b111) begin
          idx_d   = '0;
          state_d = StMac;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          idx_d     = '0;
          state_d   = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + term;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd2) state_d = StOut;
      end
      StOut: begin
        mix_d       = out_val;
        mix_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dato_q      <= '0;
      for (int k = 0; k < 3; k++) begin
        gain_q[k] <= '0;
        cap_q[k]  <= '0;
      end
      mask_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dato_q      <= dato_d;
      gain_q      <= gain_d;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign filt_start_o = (state_q == StLaunch);
  assign busy_o       = (state_q != StIdle);
  assign filt_dato_o  = dato_q;
  assign mix_o        = mix_q;
  assign mix_valid_o  = mix_valid_q;
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_eq_mix_sequencer.sv
// Directed bench for eq_mix_sequencer: vector table for the mix arithmetic plus
// hand-written timeout, overrun and mid-MAC reset sequences.
module tb_eq_mix_sequencer;

  localparam int W = 29;

  logic         clk_i = 1'b0;
  logic         reset;
  logic         sample_valid_i;
  logic [W-1:0] sample_i;
  logic [W-1:0] gain1_i, gain2_i, gain3_i;
  logic         clr_flags_i;
  logic         filt_start_o;
  logic [W-1:0] filt_dato_o;
  logic [2:0]   band_done_i;
  logic [W-1:0] band1_i, band2_i, band3_i;
  logic [W-1:0] mix_o;
  logic         mix_valid_o;
  logic         busy_o;
  logic         overrun_o;
  logic         timeout_o;

  eq_mix_sequencer #(
    .TIMEOUT_CYC(16),
    .W          (W)
  ) dut (
    .clk_i         (clk_i),
    .reset         (reset),
    .sample_valid_i(sample_valid_i),
    .sample_i      (sample_i),
    .gain1_i       (gain1_i),
    .gain2_i       (gain2_i),
    .gain3_i       (gain3_i),
    .clr_flags_i   (clr_flags_i),
    .filt_start_o  (filt_start_o),
    .filt_dato_o   (filt_dato_o),
    .band_done_i   (band_done_i),
    .band1_i       (band1_i),
    .band2_i       (band2_i),
    .band3_i       (band3_i),
    .mix_o         (mix_o),
    .mix_valid_o   (mix_valid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;

  typedef struct {
    string  name;
    int     g1, g2, g3;
    int     b1, b2, b3;
    int     s;
    longint exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (filt_start_o) starts++;
  endtask

  function automatic longint smix();
    logic signed [W-1:0] v;
    v = mix_o;
    return longint'(v);
  endfunction

  // Returns cycles from the done edge to mix_valid_o, or -1 if it never came.
  task automatic wait_valid(input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (mix_valid_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    starts = 0;
    sample_i = W'(v.s);
    gain1_i = W'(v.g1); gain2_i = W'(v.g2); gain3_i = W'(v.g3);
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    tick();
    tick();
    band1_i = W'(v.b1); band2_i = W'(v.b2); band3_i = W'(v.b3);
    band_done_i = 3'b111;
    tick();
    band_done_i = 3'b000;
    wait_valid(20, lat);
    check({v.name, "_mix"}, smix(), v.exp);
    check({v.name, "_latency"}, lat, 4);
    tick();
    check({v.name, "_valid_one_cycle"}, mix_valid_o, 0);
    check({v.name, "_starts"}, starts, 1);
  endtask

  initial begin
    int lat;

    vecs[0] = '{"unity", 65536, 65536, 65536, 100, 200, 300, 1, 600};
    vecs[1] = '{"round_pos", 32768, 0, 0, 1001, 0, 0, 2, 500};
    vecs[2] = '{"round_neg", 32768, 0, 0, -1001, 0, 0, 3, -501};
`ifdef EQ_MIX_SAT_EN
    vecs[3] = '{"sat_pos", 65536, 65536, 65536, 200000000, 200000000, 200000000, 4, 268435455};
    vecs[6] = '{"sat_neg", 65536, 65536, 65536, -200000000, -200000000, -200000000, 7,
                -268435456};
`else
    vecs[3] = '{"sat_pos", 65536, 65536, 65536, 200000000, 200000000, 200000000, 4, 63129088};
    vecs[6] = '{"sat_neg", 65536, 65536, 65536, -200000000, -200000000, -200000000, 7,
                -63129088};
`endif
    vecs[4] = '{"mixed", 131072, -65536, 16384, 1000, 500, -4000, 5, 500};
    vecs[5] = '{"neg_frac", -32768, 0, 0, 3, 0, 0, 6, -2};

    reset = 1'b0;
    sample_valid_i = 1'b0; sample_i = '0;
    gain1_i = '0; gain2_i = '0; gain3_i = '0;
    clr_flags_i = 1'b0; band_done_i = '0;
    band1_i = '0; band2_i = '0; band3_i = '0;
    tick();
    tick();
    check("rst_mix", mix_o, 0);
    check("rst_mix_valid", mix_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_start", filt_start_o, 0);
    check("rst_dato", filt_dato_o, 0);
    check("rst_flags", {overrun_o, timeout_o}, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Timeout with band 3 missing; a repeat band-1 pulse must not overwrite the first capture.
    starts = 0;
    sample_i = W'(11);
    gain1_i = W'(65536); gain2_i = W'(65536); gain3_i = W'(65536);
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    tick();
    band1_i = W'(10); band2_i = W'(20); band3_i = W'(5000);
    band_done_i = 3'b011;
    tick();
    band1_i = W'(999);
    band_done_i = 3'b001;
    tick();
    band_done_i = 3'b000;
    check("to_busy", busy_o, 1);
    check("to_not_yet", timeout_o, 0);
    wait_valid(40, lat);
    check("to_valid_seen", lat > 0, 1);
    check("to_flag", timeout_o, 1);
    check("to_mix", smix(), 30);
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    check("to_cleared", timeout_o, 0);

    // Overrun during WAIT, with new gains and a clear in the same cycle.
    starts = 0;
    sample_i = W'(777);
    gain1_i = W'(65536); gain2_i = W'(65536); gain3_i = W'(65536);
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    tick();
    sample_i = W'(555);
    gain1_i = '0; gain2_i = '0; gain3_i = '0;
    sample_valid_i = 1'b1;
    clr_flags_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    clr_flags_i = 1'b0;
    check("ovr_flag", overrun_o, 1);
    check("ovr_dato", filt_dato_o, 777);
    band1_i = W'(1); band2_i = W'(2); band3_i = W'(3);
    band_done_i = 3'b111;
    tick();
    band_done_i = 3'b000;
    wait_valid(20, lat);
    check("ovr_latency", lat, 4);
    check("ovr_mix", smix(), 6);
    check("ovr_starts", starts, 1);
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    check("ovr_cleared", overrun_o, 0);

    // Asynchronous reset while in MAC.
    sample_i = W'(42);
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    tick();
    band1_i = W'(7); band2_i = W'(8); band3_i = W'(9);
    band_done_i = 3'b111;
    tick();
    band_done_i = 3'b000;
    tick();
    check("mac_busy", busy_o, 1);
    reset = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_mix", mix_o, 0);
    check("arst_dato", filt_dato_o, 0);
    check("arst_valid", mix_valid_o, 0);
    tick();
    reset = 1'b1;
    lat = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (mix_valid_o) lat++;
    end
    check("arst_no_valid", lat, 0);
    run_vec('{"post_reset", 65536, 65536, 65536, 7, 8, 9, 42, 24});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
